imm_gen_arbiter: RTL and testbench
==================================

# imm_gen_arbiter

Shares the single combinational `imm_gen` immediate decoder between two requesters: port 0 for the decode stage and port 1 for the fetch-side branch-target precompute. Each requester presents a 32-bit RV32I instruction over a valid/ready handshake. The arbiter grants one requester per cycle and drives the granted instruction's bits [31:2] into an internally instantiated `imm_gen`. It registers the 32-bit immediate into a single-entry response buffer that is tagged with the requester ID.

## Interface
- No parameters; data widths are fixed by RV32I (instruction 32, immediate 32).
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: requester 0 has an instruction.
- `req0_inst` in 32: requester 0 instruction word.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req1_valid` in 1: requester 1 has an instruction.
- `req1_inst` in 32: requester 1 instruction word.
- `req1_ready` out 1: requester 1 accepted this cycle.
- `rsp_valid` out 1: response buffer holds a result.
- `rsp_id` out 1: requester that owns the response (0 or 1).
- `rsp_imm` out 32: sign-extended immediate from `imm_gen`.
- `rsp_ready` in 1: consumer takes the response this cycle.

## Operation
- Requester contract: once `reqN_valid` is high, it stays high and `reqN_inst` stays stable until `reqN_ready` is high.
- Accept condition: `can_accept = !rsp_valid | rsp_ready`. The buffer is empty or drains in the same cycle.
- Grant selection is combinational from the valid signals and the priority state:
  - Only one valid requester: it is granted.
  - Both valid: the winner is set by the priority mode (see Configuration).
- `reqN_ready = grant_N & can_accept`. The two ready signals are never high in the same cycle.
- Datapath: a mux selects the granted `reqN_inst[31:2]` and feeds `imm_gen.inst`. If there is no grant, the mux selects `req0_inst`; the result is unused.
- Response buffer update, on accept (a ready high):
  - `rsp_valid` ← 1
  - `rsp_imm` ← `imm_gen.imm`
  - `rsp_id` ← granted index
- Response buffer update, if `rsp_ready & rsp_valid` and no accept: `rsp_valid` ← 0. `rsp_imm` and `rsp_id` hold their last values.
- If `rsp_ready` is high and a new accept happens in the same cycle, the buffer is overwritten with the new result. No bubble is inserted.
- `rsp_ready` while `rsp_valid`=0 has no effect.
- Priority state `last_grant` (1 bit) is updated to the granted index on every accept.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_imm`=32'h0
  - `last_grant`=1, so requester 0 wins the first tie
  - `req0_ready`/`req1_ready` follow their combinational equations, which give 0 while both valid inputs are 0.
- Latency: an instruction accepted at edge N appears on `rsp_*` after edge N+1 completes, i.e. `rsp_valid` is high in cycle N+1.
- Throughput: one immediate per cycle while `rsp_ready` is held high.
- Backpressure: with `rsp_valid`=1 and `rsp_ready`=0, both readies are 0. The buffer and `last_grant` hold.
- Reset mid-operation: a pending response is dropped, and no ready is asserted in the reset cycle.
  - Requesters hold their valid signals and are re-arbitrated starting from `last_grant`=1.
- There are no combinational paths from `rsp_ready` to `rsp_*`. Paths from `rsp_ready` to `reqN_ready` are allowed.

## Configuration
- `IMM_ARB_RR_EN` defined: round-robin priority. On a tie, the grant goes to `!last_grant`.
- `IMM_ARB_RR_EN` undefined: fixed priority. On a tie, requester 0 always wins.
  - `last_grant` is still maintained but does not affect selection.
  - Requester 1 can starve while requester 0 stays valid.

## Test plan
- Reset, then `req0_valid`=1 with `req0_inst`=32'hFFF00013 and `rsp_ready`=1.
  - Required: `req0_ready`=1 in the first post-reset cycle, then the next cycle shows `rsp_valid`=1, `rsp_id`=0, `rsp_imm`=32'hFFFFFFFF.
- Both requesters valid and held for 4 cycles: req0=32'hFE000FE3, req1=32'hD545506F, `rsp_ready`=1.
  - With `IMM_ARB_RR_EN`: the response sequence alternates id 0 (imm 32'hFFFFFFFE), id 1 (imm 32'hFFF55554), 0, 1.
  - Without `IMM_ARB_RR_EN`: id 0 for all 4 responses.
- Backpressure: `rsp_ready`=0 for 3 cycles with req1 valid (32'h000F8F93).
  - Required: `rsp_valid` stays 1, `rsp_imm`/`rsp_id` are unchanged, and `req1_ready`=0 in all three cycles.
  - When `rsp_ready` rises: `req1_ready`=1 in the same cycle, and the next cycle shows `rsp_id`=1, `rsp_imm`=32'h00000000.
- Drain with no new request: `rsp_ready`=1 and both valids 0.
  - Required: `rsp_valid` falls the next cycle, and `rsp_imm` holds its last value.
- Reset asserted while `rsp_valid`=1 and both requesters are valid.
  - Required: after the edge, `rsp_valid`=0, `rsp_imm`=0, `rsp_id`=0, and no ready was high during the reset cycle.
  - The first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/imm_gen_arbiter.sv
// Two-port arbiter sharing one RV32I immediate decoder, with a single-entry tagged response buffer.
// Define IMM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins every tie.

module imm_gen (
  input  logic [31:2] inst,
  output logic [31:0] imm
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [4:0] opcode;
  assign opcode = inst[6:2];

  always_comb begin
    imm = 32'h0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'h0};
      OP_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = 32'h0;
    endcase
  end

endmodule

module imm_gen_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_inst,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_inst,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_imm,
  input  logic        rsp_ready
);

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_imm_q, rsp_imm_d;
  logic        last_grant_q, last_grant_d;

  logic        grant0, grant1;
  logic        can_accept;
  logic        accept;
  logic [31:2] dec_inst;
  logic [31:0] dec_imm;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef IMM_ARB_RR_EN
      grant1 = ~last_grant_q;
      grant0 = last_grant_q;
`else
      grant0 = 1'b1;
`endif
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  assign can_accept = ~rsp_valid_q | rsp_ready;

  // Readies are held low while reset is asserted so nothing is handed off into a buffer being cleared.
  assign req0_ready = grant0 & can_accept & ~reset;
  assign req1_ready = grant1 & can_accept & ~reset;
  assign accept     = req0_ready | req1_ready;

  assign dec_inst = grant1 ? req1_inst[31:2] : req0_inst[31:2];

  imm_gen u_imm_gen (
    .inst (dec_inst),
    .imm  (dec_imm)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_imm_d    = rsp_imm_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant1;
      rsp_imm_d    = dec_imm;
      last_grant_d = grant1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_imm_q    <= 32'h0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_imm_q    <= rsp_imm_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_imm   = rsp_imm_q;

endmodule

// File: tb/tb_imm_gen_arbiter.sv
// Scoreboard bench for imm_gen_arbiter: accepts push expected responses, a monitor pops on consumption.
// Tie-order expectations follow IMM_ARB_RR_EN as defined for the build.

module tb_imm_gen_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_inst, req1_inst;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [31:0] rsp_imm;

  logic [31:0] exp0, exp1;
  logic [32:0] sb_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imm_gen_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_inst  (req0_inst),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_inst  (req1_inst),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_imm    (rsp_imm),
    .rsp_ready  (rsp_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected responses are queued on the handshake, using the hand-computed immediate for that requester.
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_ready && req0_valid) sb_q.push_back({1'b0, exp0});
      if (req1_ready && req1_valid) sb_q.push_back({1'b1, exp1});
    end
  end

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", {31'h0, rsp_valid}, 32'h0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("sb_id", {31'h0, rsp_id}, {31'h0, e[32]});
        check("sb_imm", rsp_imm, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  logic [3:0] tie_g0;
  logic [3:0] tie_g1;

  initial begin
`ifdef IMM_ARB_RR_EN
    tie_g0 = 4'b0101;
    tie_g1 = 4'b1010;
`else
    tie_g0 = 4'b1111;
    tie_g1 = 4'b0000;
`endif
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_inst = 32'h0; req1_inst = 32'h0;
    exp0 = 32'h0; exp1 = 32'h0;
    rsp_ready = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_id", {31'h0, rsp_id}, 32'h0);
    check("rst_imm", rsp_imm, 32'h0);
    check("rst_ready", {30'h0, req1_ready, req0_ready}, 32'h0);

    // single request on port 0
    step();
    reset = 1'b0;
    req0_valid = 1'b1; req0_inst = 32'hFFF00013; exp0 = 32'hFFFFFFFF;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t1_req0_ready", {31'h0, req0_ready}, 32'h1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("t1_rsp_id", {31'h0, rsp_id}, 32'h0);
    check("t1_rsp_imm", rsp_imm, 32'hFFFFFFFF);

    // fresh priority state, then a 4-cycle tie
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0_valid = 1'b1; req0_inst = 32'hFE000FE3; exp0 = 32'hFFFFFFFE;
    req1_valid = 1'b1; req1_inst = 32'hD545506F; exp1 = 32'hFFF55554;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("tie_req0_ready", {31'h0, req0_ready}, {31'h0, tie_g0[k]});
      check("tie_req1_ready", {31'h0, req1_ready}, {31'h0, tie_g1[k]});
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // drain with no new request
    @(negedge clk);
    check("drain_pre_valid", {31'h0, rsp_valid}, 32'h1);
    step();
    @(negedge clk);
    check("drain_valid", {31'h0, rsp_valid}, 32'h0);
    check("drain_imm_hold", rsp_imm, tie_g1[3] ? 32'hFFF55554 : 32'hFFFFFFFE);

    // fill the buffer, then backpressure with req1 waiting
    step();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_inst = 32'hFFF00013; exp0 = 32'hFFFFFFFF;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_inst = 32'h000F8F93; exp1 = 32'h00000000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_id", {31'h0, rsp_id}, 32'h0);
      check("bp_imm", rsp_imm, 32'hFFFFFFFF);
      check("bp_req1_ready", {31'h0, req1_ready}, 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'h0, req1_ready}, 32'h1);
    step();
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("bp_rsp_id", {31'h0, rsp_id}, 32'h1);
    check("bp_rsp_imm", rsp_imm, 32'h00000000);

    // reset while a response is pending and both requesters are valid
    step();
    reset = 1'b1;
    req0_valid = 1'b1; req0_inst = 32'hFE000FE3; exp0 = 32'hFFFFFFFE;
    req1_valid = 1'b1; req1_inst = 32'hD545506F; exp1 = 32'hFFF55554;
    @(negedge clk);
    check("rr_ready_in_reset", {30'h0, req1_ready, req0_ready}, 32'h0);
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("rr_valid", {31'h0, rsp_valid}, 32'h0);
    check("rr_imm", rsp_imm, 32'h0);
    check("rr_id", {31'h0, rsp_id}, 32'h0);
    check("rr_first_grant", {30'h0, req1_ready, req0_ready}, 32'h1);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step();
    check("sb_empty", sb_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
